// File: rtl/pipelined_control_unit.sv
`timescale 1ns/1ps
// pipelined_control_unit
// Decodes the ID instruction into the control bundle and carries it through
// the ID/EX, EX/MEM and MEM/WB registers. Produces IF/ID stall and flush for
// load-use hazards, multi-cycle DIV occupancy of EX and taken branches.
// Optional feature macro: CU_ILLEGAL_TRAP_EN
//   defined   : illegal opcodes enter EX as a bubble and pulse illegal_op.
//   undefined : illegal opcodes decode as NOP (valid) and illegal_op stays 0.
module pipelined_control_unit #(
    parameter int OPCODE_W   = 4,
    parameter int REG_ADDR_W = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid_id,
    input  logic [OPCODE_W-1:0]   opcode_id,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic [REG_ADDR_W-1:0] rd_id,
    input  logic                  branch_taken_ex,
    output logic                  stall_if_id,
    output logic                  flush_id,
    output logic                  div_busy,
    output logic                  illegal_op,
    output logic                  ex_valid,
    output logic [1:0]            ex_branch_cond,
    output logic [1:0]            ex_extend_sel,
    output logic                  ex_alu_op_b_sel,
    output logic [1:0]            ex_alu_control,
    output logic                  ex_set_flags,
    output logic                  mem_valid,
    output logic                  mem_we,
    output logic                  mem_byte,
    output logic                  wb_valid,
    output logic                  wb_reg_we,
    output logic                  wb_sel,
    output logic [REG_ADDR_W-1:0] wb_rd
);

    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef struct packed {
        logic [1:0] cond;
        logic       reg_we;
        logic [1:0] ext;
        logic       opb;
        logic [1:0] alu;
        logic       flags;
        logic       mem_we;
        logic       byte_sel;
        logic       wb_sel;
        logic       use_rs1;
        logic       use_rs2;
    } dec_t;

    typedef struct packed {
        logic                  valid;
        logic [1:0]            cond;
        logic                  reg_we;
        logic [1:0]            ext;
        logic                  opb;
        logic [1:0]            alu;
        logic                  flags;
        logic                  mem_we;
        logic                  byte_sel;
        logic                  wb_sel;
        logic [REG_ADDR_W-1:0] rd;
    } ex_t;

    typedef struct packed {
        logic                  valid;
        logic                  mem_we;
        logic                  byte_sel;
        logic                  reg_we;
        logic                  wb_sel;
        logic [REG_ADDR_W-1:0] rd;
    } mem_t;

    typedef struct packed {
        logic                  valid;
        logic                  reg_we;
        logic                  wb_sel;
        logic [REG_ADDR_W-1:0] rd;
    } wb_t;

    // Opcode decode; anything outside the table (including wide opcodes) is a NOP bundle.
    function automatic dec_t decode(input logic [OPCODE_W-1:0] op);
        dec_t d;
        d = '0;
        if ((op >> 3'd4) != {OPCODE_W{1'b0}}) begin
            d = '0;
        end else begin
            case (op[3:0])
                4'h0: d = '0;
                4'h1: begin d.cond = 2'b01; d.ext = 2'b10; d.opb = 1'b1; end
                4'h2: begin d.cond = 2'b10; d.ext = 2'b10; d.alu = 2'b01; d.flags = 1'b1;
                            d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
                4'h3: begin d.cond = 2'b11; d.ext = 2'b10; d.alu = 2'b01; d.flags = 1'b1;
                            d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
                4'h4, 4'h5: begin d.reg_we = 1'b1; d.ext = 2'b01; d.opb = 1'b1; d.wb_sel = 1'b1;
                            d.byte_sel = op[0]; d.use_rs1 = 1'b1; end
                4'h6, 4'h7: begin d.mem_we = 1'b1; d.ext = 2'b01; d.opb = 1'b1;
                            d.byte_sel = op[0]; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
                4'h8: begin d.reg_we = 1'b1; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
                4'h9: begin d.reg_we = 1'b1; d.ext = 2'b01; d.opb = 1'b1; d.use_rs1 = 1'b1; end
                4'hA: begin d.reg_we = 1'b1; d.alu = 2'b01; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
                4'hB: begin d.reg_we = 1'b1; d.alu = 2'b10; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
                4'hC: begin d.reg_we = 1'b1; d.alu = 2'b11; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
                default: d = '0;
            endcase
        end
        return d;
    endfunction

`ifdef CU_ILLEGAL_TRAP_EN
    // Opcode lies outside the defined instruction set.
    function automatic logic is_illegal(input logic [OPCODE_W-1:0] op);
        logic ill;
        if ((op >> 3'd4) != {OPCODE_W{1'b0}}) begin
            ill = 1'b1;
        end else begin
            ill = (op[3:0] > 4'hC);
        end
        return ill;
    endfunction
`endif

    ex_t              r_ex;
    mem_t             r_mem;
    wb_t              r_wb;
    logic [CNT_W-1:0] r_div_cnt;
    logic             r_div_busy;
    logic             r_illegal_op;

    dec_t             w_dec;
    logic             w_ill_id;
    logic             w_flush;
    logic             w_div_hold;
    logic             w_load_use;
    logic             w_advance;
    logic             w_issue;
    logic             w_trap;
    ex_t              w_ex_next;
    mem_t             w_mem_next;
    logic [CNT_W-1:0] w_cnt_next;

    // Hazard detection and next-state selection for the EX and MEM stages.
    always_comb begin
        w_dec = decode(opcode_id);
`ifdef CU_ILLEGAL_TRAP_EN
        w_ill_id = is_illegal(opcode_id);
`else
        w_ill_id = 1'b0;
`endif
        w_flush    = branch_taken_ex & r_ex.valid;
        w_div_hold = (r_div_cnt != {CNT_W{1'b0}});
        w_load_use = r_ex.valid & r_ex.wb_sel & (r_ex.rd != {REG_ADDR_W{1'b0}}) & instr_valid_id &
                     ((w_dec.use_rs1 & (rs1_id == r_ex.rd)) | (w_dec.use_rs2 & (rs2_id == r_ex.rd)));
        w_advance  = ~w_flush & ~w_div_hold & ~w_load_use;
        w_issue    = w_advance & instr_valid_id & ~w_ill_id;
        w_trap     = w_advance & instr_valid_id & w_ill_id;

        w_ex_next  = '0;
        w_mem_next = '0;
        w_cnt_next = {CNT_W{1'b0}};
        if (w_div_hold & ~w_flush) begin
            // DIV keeps EX; downstream sees bubbles until the count runs out.
            w_ex_next  = r_ex;
            w_mem_next = '0;
            w_cnt_next = r_div_cnt - CNT_W'(1);
        end else begin
            w_mem_next.valid    = r_ex.valid;
            w_mem_next.mem_we   = r_ex.mem_we;
            w_mem_next.byte_sel = r_ex.byte_sel;
            w_mem_next.reg_we   = r_ex.reg_we;
            w_mem_next.wb_sel   = r_ex.wb_sel;
            w_mem_next.rd       = r_ex.rd;
            if (w_issue) begin
                w_ex_next.valid    = 1'b1;
                w_ex_next.cond     = w_dec.cond;
                w_ex_next.reg_we   = w_dec.reg_we;
                w_ex_next.ext      = w_dec.ext;
                w_ex_next.opb      = w_dec.opb;
                w_ex_next.alu      = w_dec.alu;
                w_ex_next.flags    = w_dec.flags;
                w_ex_next.mem_we   = w_dec.mem_we;
                w_ex_next.byte_sel = w_dec.byte_sel;
                w_ex_next.wb_sel   = w_dec.wb_sel;
                w_ex_next.rd       = rd_id;
                if (w_dec.alu == 2'b10) begin
                    w_cnt_next = CNT_W'(DIV_CYCLES - 1);
                end else begin
                    w_cnt_next = {CNT_W{1'b0}};
                end
            end else begin
                w_ex_next  = '0;
                w_cnt_next = {CNT_W{1'b0}};
            end
        end
    end

    // Pipeline stage registers, divide counter and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex         <= '0;
            r_mem        <= '0;
            r_wb         <= '0;
            r_div_cnt    <= {CNT_W{1'b0}};
            r_div_busy   <= 1'b0;
            r_illegal_op <= 1'b0;
        end else begin
            r_ex         <= w_ex_next;
            r_mem        <= w_mem_next;
            r_wb.valid   <= r_mem.valid;
            r_wb.reg_we  <= r_mem.reg_we;
            r_wb.wb_sel  <= r_mem.wb_sel;
            r_wb.rd      <= r_mem.rd;
            r_div_cnt    <= w_cnt_next;
            r_div_busy   <= (w_cnt_next != {CNT_W{1'b0}});
            r_illegal_op <= w_trap;
        end
    end

    assign stall_if_id     = ~w_flush & (w_div_hold | w_load_use);
    assign flush_id        = w_flush;
    assign div_busy        = r_div_busy;
    assign illegal_op      = r_illegal_op;
    assign ex_valid        = r_ex.valid;
    assign ex_branch_cond  = r_ex.cond;
    assign ex_extend_sel   = r_ex.ext;
    assign ex_alu_op_b_sel = r_ex.opb;
    assign ex_alu_control  = r_ex.alu;
    assign ex_set_flags    = r_ex.flags;
    assign mem_valid       = r_mem.valid;
    assign mem_we          = r_mem.mem_we;
    assign mem_byte        = r_mem.byte_sel;
    assign wb_valid        = r_wb.valid;
    assign wb_reg_we       = r_wb.reg_we;
    assign wb_sel          = r_wb.wb_sel;
    assign wb_rd           = r_wb.rd;

endmodule

// File: tb/tb_pipelined_control_unit.sv
`timescale 1ns/1ps
// Testbench for pipelined_control_unit: directed scenarios plus randomized
// instruction streams, checked against an instruction-level reference model.
module tb_pipelined_control_unit;

    localparam int OPCODE_W   = 4;
    localparam int REG_ADDR_W = 4;
    localparam int DIV_CYCLES = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  instr_valid_id;
    logic [OPCODE_W-1:0]   opcode_id;
    logic [REG_ADDR_W-1:0] rs1_id, rs2_id, rd_id;
    logic                  branch_taken_ex;
    logic                  stall_if_id, flush_id, div_busy, illegal_op;
    logic                  ex_valid, ex_alu_op_b_sel, ex_set_flags;
    logic [1:0]            ex_branch_cond, ex_extend_sel, ex_alu_control;
    logic                  mem_valid, mem_we, mem_byte;
    logic                  wb_valid, wb_reg_we, wb_sel;
    logic [REG_ADDR_W-1:0] wb_rd;

    pipelined_control_unit #(
        .OPCODE_W(OPCODE_W), .REG_ADDR_W(REG_ADDR_W), .DIV_CYCLES(DIV_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid_id(instr_valid_id), .opcode_id(opcode_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id), .branch_taken_ex(branch_taken_ex),
        .stall_if_id(stall_if_id), .flush_id(flush_id), .div_busy(div_busy), .illegal_op(illegal_op),
        .ex_valid(ex_valid), .ex_branch_cond(ex_branch_cond), .ex_extend_sel(ex_extend_sel),
        .ex_alu_op_b_sel(ex_alu_op_b_sel), .ex_alu_control(ex_alu_control), .ex_set_flags(ex_set_flags),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_byte(mem_byte),
        .wb_valid(wb_valid), .wb_reg_we(wb_reg_we), .wb_sel(wb_sel), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (instruction level) ----------------
    typedef struct { bit v; int op; int rd; } slot_t;
    slot_t m_ex, m_mem, m_wb;
    int    m_hold;   // extra cycles the DIV in EX still has to stay
    bit    m_ill;

    // {cond[1:0], reg_we, ext[1:0], opb, alu[1:0], flags, mem_we, byte, wb_sel}
    function automatic logic [11:0] spec_ctrl(input int op);
        case (op)
            1:  return {2'b01, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
            2:  return {2'b10, 1'b0, 2'b10, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
            3:  return {2'b11, 1'b0, 2'b10, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
            4:  return {2'b00, 1'b1, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
            5:  return {2'b00, 1'b1, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
            6:  return {2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
            7:  return {2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
            8:  return {2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
            9:  return {2'b00, 1'b1, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
            10: return {2'b00, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
            11: return {2'b00, 1'b1, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
            12: return {2'b00, 1'b1, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0};
            default: return 12'd0;
        endcase
    endfunction

    function automatic bit reads_rs1(input int op);
        return (op >= 2) && (op <= 12);
    endfunction

    function automatic bit reads_rs2(input int op);
        return (op == 2) || (op == 3) || (op == 6) || (op == 7) || (op == 8) || ((op >= 10) && (op <= 12));
    endfunction

    task automatic model_reset();
        m_ex = '{0, 0, 0}; m_mem = '{0, 0, 0}; m_wb = '{0, 0, 0};
        m_hold = 0; m_ill = 1'b0;
    endtask

    task automatic check_outputs();
        logic [11:0] ce, cm, cw;
        ce = m_ex.v  ? spec_ctrl(m_ex.op)  : 12'd0;
        cm = m_mem.v ? spec_ctrl(m_mem.op) : 12'd0;
        cw = m_wb.v  ? spec_ctrl(m_wb.op)  : 12'd0;
        check_val("ex_valid", ex_valid, m_ex.v);
        check_val("ex_ctrl", {ex_branch_cond, ex_extend_sel, ex_alu_op_b_sel, ex_alu_control, ex_set_flags},
                  {ce[11:10], ce[8:7], ce[6], ce[5:4], ce[3]});
        check_val("mem_valid", mem_valid, m_mem.v);
        check_val("mem_we", mem_we, cm[2]);
        check_val("mem_byte", mem_byte, cm[1]);
        check_val("wb_valid", wb_valid, m_wb.v);
        check_val("wb_reg_we", wb_reg_we, cw[9]);
        check_val("wb_sel", wb_sel, cw[0]);
        check_val("wb_rd", wb_rd, m_wb.v ? m_wb.rd : 0);
        check_val("div_busy", div_busy, m_hold > 0);
        check_val("illegal_op", illegal_op, m_ill);
    endtask

    // One clock: drive ID at negedge, check, then advance the model at posedge.
    task automatic step(input bit iv, input int op, input int rs1, input int rs2, input int rd,
                        input bit taken, output bit stalled);
        bit fl, hold, lu, st;
        instr_valid_id  = iv;
        opcode_id       = op[OPCODE_W-1:0];
        rs1_id          = rs1[REG_ADDR_W-1:0];
        rs2_id          = rs2[REG_ADDR_W-1:0];
        rd_id           = rd[REG_ADDR_W-1:0];
        branch_taken_ex = taken;
        #2;
        fl   = taken && m_ex.v;
        hold = (m_hold > 0);
        lu   = m_ex.v && ((m_ex.op == 4) || (m_ex.op == 5)) && (m_ex.rd != 0) && iv &&
               ((reads_rs1(op) && (rs1 == m_ex.rd)) || (reads_rs2(op) && (rs2 == m_ex.rd)));
        st   = !fl && (hold || lu);
        check_val("stall_if_id", stall_if_id, st);
        check_val("flush_id", flush_id, fl);
        check_outputs();
        @(posedge clk);
        m_wb  = m_mem;
        m_ill = 1'b0;
        if (fl) begin
            m_mem = m_ex; m_ex = '{0, 0, 0}; m_hold = 0;
        end else if (hold) begin
            m_mem = '{0, 0, 0}; m_hold = m_hold - 1;
        end else if (lu) begin
            m_mem = m_ex; m_ex = '{0, 0, 0};
        end else begin
            m_mem = m_ex; m_hold = 0;
            if (!iv) begin
                m_ex = '{0, 0, 0};
`ifdef CU_ILLEGAL_TRAP_EN
            end else if (op > 12) begin
                m_ex = '{0, 0, 0}; m_ill = 1'b1;
`endif
            end else begin
                m_ex = '{1, op, rd};
                if (op == 11) m_hold = DIV_CYCLES - 1;
            end
        end
        stalled = st;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit s;
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 1'b0, s);
    endtask

    // Present an instruction until ID accepts it (bounded).
    task automatic issue(input int op, input int rs1, input int rs2, input int rd);
        bit s;
        int n;
        s = 1'b1; n = 0;
        while (s && (n < 20)) begin
            step(1'b1, op, rs1, rs2, rd, 1'b0, s);
            n++;
        end
        if (s) check_val("issue_bound", n, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ex"}, {ex_valid, ex_branch_cond, ex_extend_sel, ex_alu_op_b_sel,
                                 ex_alu_control, ex_set_flags}, 32'd0);
        check_val({tag, "_mem"}, {mem_valid, mem_we, mem_byte}, 32'd0);
        check_val({tag, "_wb"}, {wb_valid, wb_reg_we, wb_sel, wb_rd}, 32'd0);
        check_val({tag, "_ctl"}, {stall_if_id, flush_id, div_busy, illegal_op}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bit s;
        int op, r1, r2, rd, busy_cnt, stall_cnt;
        bit iv, tk;

        rst_n = 1'b0; instr_valid_id = 1'b0; opcode_id = '0; rs1_id = '0; rs2_id = '0;
        rd_id = '0; branch_taken_ex = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // ADD rd=3: one cycle to EX, two more to WB.
        issue(8, 1, 2, 3);
        check_val("add_ex_valid", ex_valid, 1);
        check_val("add_ex_alu", ex_alu_control, 0);
        idle(2);
        check_val("add_wb_reg_we", wb_reg_we, 1);
        check_val("add_wb_rd", wb_rd, 3);
        idle(2);

        // Load-use on r5, then no hazard through r0.
        issue(4, 0, 0, 5);
        step(1'b1, 8, 5, 1, 6, 1'b0, s);
        check_val("lu_bubble", ex_valid, 0);
        issue(8, 5, 1, 6);
        check_val("lu_add_ex", ex_valid, 1);
        idle(3);
        issue(4, 0, 0, 0);
        issue(8, 0, 0, 7);
        idle(3);

        // DIV hold length.
        issue(11, 1, 2, 4);
        busy_cnt = 0; stall_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (div_busy) busy_cnt++;
            if (stall_if_id) stall_cnt++;
            idle(1);
        end
        check_val("div_busy_cycles", busy_cnt, DIV_CYCLES - 1);
        check_val("div_stall_cycles", stall_cnt, DIV_CYCLES - 1);

        // Taken-branch flush beats a load-use stall; then a real BEQ flush.
        issue(4, 0, 0, 6);
        step(1'b1, 8, 6, 0, 7, 1'b1, s);
        check_val("flush_bubble", ex_valid, 0);
        issue(2, 1, 2, 0);
        step(1'b1, 9, 1, 1, 2, 1'b1, s);
        check_val("beq_flush_bubble", ex_valid, 0);
        idle(3);

        // Illegal opcode E.
        issue(14, 0, 0, 9);
`ifdef CU_ILLEGAL_TRAP_EN
        check_val("ill_ex_valid", ex_valid, 0);
        check_val("ill_pulse", illegal_op, 1);
`else
        check_val("ill_ex_valid", ex_valid, 1);
        check_val("ill_pulse", illegal_op, 0);
`endif
        idle(1);
        check_val("ill_pulse_end", illegal_op, 0);
        idle(2);

        // Randomized streams with hazards on a small register set.
        s = 1'b0; iv = 1'b0; op = 0; r1 = 0; r2 = 0; rd = 0;
        for (int k = 0; k < 400; k++) begin
            if (!s) begin
                iv = ($urandom_range(0, 9) < 8);
                op = $urandom_range(0, 15);
                r1 = $urandom_range(0, 3);
                r2 = $urandom_range(0, 3);
                rd = $urandom_range(0, 3);
            end
            if (m_ex.v && (m_ex.op >= 1) && (m_ex.op <= 3)) tk = $urandom_range(0, 1);
            else if (!m_ex.v) tk = $urandom_range(0, 1);
            else tk = 1'b0;
            step(iv, op, r1, r2, rd, tk, s);
        end
        idle(12);

        // Reset on the third cycle of a divide.
        issue(11, 1, 2, 4);
        idle(2);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_div_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        issue(8, 1, 2, 3);
        check_val("post_reset_add_ex", ex_valid, 1);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
